mdu_seq: RTL and testbench

- Iterative multiply/divide sequencer beside the combinational ALU in the CPU execute stage.
- Runs MULT/MULTU/DIV/DIVU as a one-bit-per-cycle shift-add / restoring-subtract loop.
- Owns the HI/LO registers and raises busy so the pipeline control can stall while an operation is in flight.

---
 rtl/mdu_seq.sv | 138 +++++++++++++
 tb/tb_mdu_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one bit per cycle.
// Ports: clock/reset, start/op/a/b request, hi_we/lo_we/wdata MTHI/MTLO, busy/done/dz/hi/lo status.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]         state;
    logic [2*WIDTH:0]   acc;
    logic [WIDTH-1:0]   opb;
    logic [CW-1:0]      count;
    logic               isdiv;
    logic               sneg;
    logic               rneg;
    logic               dzr;

    logic [WIDTH-1:0]   amag;
    logic [WIDTH-1:0]   bmag;
    logic [WIDTH:0]     msum;
    logic [2*WIDTH:0]   mnext;
    logic [2*WIDTH:0]   sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH:0]   dnext;
    logic [2*WIDTH-1:0] pfix;
    logic [WIDTH-1:0]   qfix;
    logic [WIDTH-1:0]   rfix;

    assign busy = (state != IDLE);

    assign amag = (op[0] && a[WIDTH-1]) ? -a : a;
    assign bmag = (op[0] && b[WIDTH-1]) ? -b : b;

    // Multiply: acc = {carry, upper, multiplier}; add then shift right.
    assign msum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opb} : '0);
    assign mnext = {1'b0, msum, acc[WIDTH-1:1]};

    // Divide: acc[2W-1:W] = remainder, acc[W-1:0] = quotient.
    // The bit shifted out of the remainder is kept in sh[2W] for the trial.
    assign sh    = {acc[2*WIDTH-1:0], 1'b0};
    assign trial = sh[2*WIDTH:WIDTH] - {1'b0, opb};
    assign dnext = trial[WIDTH] ? {1'b0, sh[2*WIDTH-1:0]}
                                : {1'b0, trial[WIDTH-1:0], sh[WIDTH-1:1], 1'b1};

    assign pfix = sneg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    assign qfix = sneg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rfix = rneg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            opb   <= '0;
            count <= '0;
            isdiv <= 1'b0;
            sneg  <= 1'b0;
            rneg  <= 1'b0;
            dzr   <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            dz    <= 1'b0;
        end else begin
            done <= 1'b0;
            dz   <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        isdiv <= op[1];
                        count <= CW'(WIDTH);
                        if (op[1] && b == '0) begin
                            // Reuse the divide fix-up path: rem=a, quo=all ones.
                            acc   <= {1'b0, a, {WIDTH{1'b1}}};
                            opb   <= '0;
                            sneg  <= 1'b0;
                            rneg  <= 1'b0;
                            dzr   <= 1'b1;
                            state <= FIX;
                        end else if (op[1]) begin
                            acc   <= {{(WIDTH+1){1'b0}}, amag};
                            opb   <= bmag;
                            sneg  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                            rneg  <= op[0] & a[WIDTH-1];
                            dzr   <= 1'b0;
                            state <= CALC;
                        end else begin
                            acc   <= {{(WIDTH+1){1'b0}}, bmag};
                            opb   <= amag;
                            sneg  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                            rneg  <= 1'b0;
                            dzr   <= 1'b0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc   <= isdiv ? dnext : mnext;
                    count <= count - CW'(1);
                    if (count == CW'(1)) state <= FIX;
                end
                FIX: begin
                    if (isdiv) begin
                        hi <= rfix;
                        lo <= qfix;
                    end else begin
                        hi <= pfix[2*WIDTH-1:WIDTH];
                        lo <= pfix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    dz    <= dzr;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed and random ops against an arithmetic model.
// Covers reset, MTHI/MTLO, latency, divide-by-zero, ignored start, and mid-op reset.
module tb_mdu_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests  = 0;
    int failed = 0;

    mdu_seq #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_model(input logic [1:0] o,
                                      input logic [31:0] x,
                                      input logic [31:0] y,
                                      output logic [31:0] eh,
                                      output logic [31:0] el,
                                      output logic ed);
        logic [63:0] p;
        longint      sx;
        longint      sy;
        int          ix;
        int          iy;
        int          q;
        int          r;
        ed = 1'b0;
        eh = '0;
        el = '0;
        case (o)
            2'b00: begin
                p  = {32'b0, x} * {32'b0, y};
                eh = p[63:32];
                el = p[31:0];
            end
            2'b01: begin
                sx = $signed(x);
                sy = $signed(y);
                p  = sx * sy;
                eh = p[63:32];
                el = p[31:0];
            end
            default: begin
                if (y == 0) begin
                    eh = x;
                    el = 32'hFFFFFFFF;
                    ed = 1'b1;
                end else if (o == 2'b10) begin
                    el = x / y;
                    eh = x % y;
                end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
                    el = 32'h80000000;
                    eh = 32'h0;
                end else begin
                    ix = x;
                    iy = y;
                    q  = ix / iy;
                    r  = ix % iy;
                    el = q;
                    eh = r;
                end
            end
        endcase
    endfunction

    // Called at a negedge; issues the op there and returns at the done negedge.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit inject);
        logic [31:0] eh;
        logic [31:0] el;
        logic        ed;
        logic [31:0] ph;
        logic [31:0] pl;
        int          n;
        int          nb;
        ref_model(o, x, y, eh, el, ed);
        ph    = hi;
        pl    = lo;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clock);
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        n     = 0;
        nb    = 0;
        while (!done && n < 100) begin
            if (busy) nb++;
            if (inject && n == 5) begin
                start = 1'b1;
                hi_we = 1'b1;
                wdata = 32'h0000AAAA;
            end
            if (inject && n == 6) begin
                start = 1'b0;
                hi_we = 1'b0;
                chk("inject_hi_hold", hi, ph);
            end
            if (n == 16) begin
                chk("hold_hi", hi, ph);
                chk("hold_lo", lo, pl);
            end
            @(negedge clock);
            n++;
        end
        chk("latency", n, ed ? 1 : 33);
        chk("busy_cycles", nb, ed ? 1 : 33);
        chk("done", done, 1'b1);
        chk("busy_at_done", busy, 1'b0);
        chk("dz", dz, ed);
        chk("hi", hi, eh);
        chk("lo", lo, el);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (2) @(negedge clock);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dz", dz, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        hi_we = 1'b1;
        wdata = 32'h55555555;
        @(negedge clock);
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = 32'h33333333;
        @(negedge clock);
        lo_we = 1'b0;
        chk("mthi", hi, 32'h55555555);
        chk("mtlo", lo, 32'h33333333);

        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        do_op(2'b01, 32'hFFFFFFFD, 32'h00000007, 1'b0);
        do_op(2'b01, 32'h80000000, 32'h80000000, 1'b0);
        do_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 1'b0);
        do_op(2'b10, 32'd100, 32'd7, 1'b0);
        do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        do_op(2'b10, 32'h00001234, 32'h0, 1'b0);
        @(negedge clock);
        chk("done_pulse_end", done, 1'b0);
        chk("dz_pulse_end", dz, 1'b0);
        do_op(2'b11, 32'h00000007, 32'h0, 1'b0);
        do_op(2'b11, 32'h00000007, 32'hFFFFFFFE, 1'b0);
        do_op(2'b00, 32'h12345678, 32'h9ABCDEF0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            logic [1:0]  ro;
            logic [31:0] rx;
            logic [31:0] ry;
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            case ($urandom_range(0, 3))
                0:       ry = 32'($urandom_range(0, 15));
                1:       ry = -32'($urandom_range(1, 15));
                default: ry = $urandom;
            endcase
            do_op(ro, rx, ry, 1'b0);
        end

        @(negedge clock);
        start = 1'b1;
        op    = 2'b11;
        a     = 32'h76543210;
        b     = 32'h00000123;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_hi", hi, 32'h0);
        chk("mid_rst_lo", lo, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        do_op(2'b11, 32'hFFFFFF00, 32'h00000009, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
